// File: rtl/write_buffer_gen2.sv
// ---------------------------------------------------------------------------
// write_buffer_gen2
//   Coalescing write buffer in front of an AXI write channel. Lines are held
//   in a circular FIFO. A write to a line that is already buffered and is not
//   the head merges byte-wise into that entry. Any other write allocates a new
//   tail entry. The head entry is presented on the AXI_* outputs until
//   AXI_valid_i retires it. A read lookup returns the youngest matching line
//   one cycle later.
//
// Optional feature (macro WBUF_FLUSH_EN):
//   adds flush_i / flush_done_o. A flush blocks all writes until the buffer
//   drains, then pulses flush_done_o for one cycle.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   wreq_i/waddr_i/wdata_i/wstrb_i   write request (line address, data, byte en)
//   wready_o            write accepted this cycle (combinational)
//   whit_o              registered pulse: last write merged into an entry
//   rreq_i/raddr_i      read lookup request
//   rhit_o/rdata_o      registered lookup result (data 0 on miss)
//   state_o/count_o     occupancy: 00 empty, 01 working, 11 full / entry count
//   AXI_wen_o/AXI_waddr_o/AXI_wdata_o/AXI_wstrb_o   head entry toward AXI
//   AXI_valid_i         write response, retires the head
//   flush_i/flush_done_o  (WBUF_FLUSH_EN only) flush request / done pulse
// ---------------------------------------------------------------------------
module write_buffer_gen2 #(
    parameter int DEPTH  = 8,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wreq_i,
    input  logic [ADDR_W-1:0]            waddr_i,
    input  logic [LINE_W-1:0]            wdata_i,
    input  logic [LINE_W/8-1:0]          wstrb_i,
    output logic                         wready_o,
    output logic                         whit_o,
    input  logic                         rreq_i,
    input  logic [ADDR_W-1:0]            raddr_i,
    output logic                         rhit_o,
    output logic [LINE_W-1:0]            rdata_o,
    output logic [1:0]                   state_o,
    output logic [$clog2(DEPTH):0]       count_o,
`ifdef WBUF_FLUSH_EN
    input  logic                         flush_i,
    output logic                         flush_done_o,
`endif
    output logic                         AXI_wen_o,
    output logic [ADDR_W-1:0]            AXI_waddr_o,
    output logic [LINE_W-1:0]            AXI_wdata_o,
    output logic [LINE_W/8-1:0]          AXI_wstrb_o,
    input  logic                         AXI_valid_i
);
    localparam int NBYTE    = LINE_W / 8;
    localparam int OFFSET_W = $clog2(NBYTE);
    localparam int TAG_W    = ADDR_W - OFFSET_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [NBYTE-1:0]  r_strb [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_whit;
    logic              r_rhit;
    logic [LINE_W-1:0] r_rdata;

    logic [TAG_W-1:0]  w_wtag;
    logic [TAG_W-1:0]  w_rtag;
    logic              w_wmatch;
    logic [PTR_W-1:0]  w_widx;
    logic              w_rmatch;
    logic [PTR_W-1:0]  w_ridx;
    logic [PTR_W-1:0]  w_scan;
    logic [LINE_W-1:0] w_bmask;
    logic [LINE_W-1:0] w_merged;
    logic              w_merge_hit;
    logic              w_flush_blk;
    logic              w_ready;
    logic              w_wacc;
    logic              w_do_merge;
    logic              w_do_alloc;
    logic              w_retire;
    logic              w_unused_ofs;

    assign w_wtag       = waddr_i[ADDR_W-1:OFFSET_W];
    assign w_rtag       = raddr_i[ADDR_W-1:OFFSET_W];
    assign w_unused_ofs = ^{waddr_i[OFFSET_W-1:0], raddr_i[OFFSET_W-1:0]};

    // Scan from head (oldest) to tail (youngest); the last hit wins, which
    // gives the youngest match. Valid entries are contiguous from the head.
    always_comb begin
        w_wmatch = 1'b0;
        w_widx   = '0;
        w_rmatch = 1'b0;
        w_ridx   = '0;
        w_scan   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan = r_head + PTR_W'(i);
            if (r_valid[w_scan] && r_tag[w_scan] == w_wtag) begin
                w_wmatch = 1'b1;
                w_widx   = w_scan;
            end
            if (r_valid[w_scan] && r_tag[w_scan] == w_rtag) begin
                w_rmatch = 1'b1;
                w_ridx   = w_scan;
            end
        end
    end

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < NBYTE; b++) begin
            w_bmask[b*8 +: 8] = {8{wstrb_i[b]}};
        end
    end

    assign w_merged = (r_data[w_widx] & ~w_bmask) | (wdata_i & w_bmask);

    // The head is never a merge target: it may already be on the AXI bus, so
    // a write to the head line allocates a fresh entry instead.
    assign w_merge_hit = w_wmatch && (w_widx != r_head);
    assign w_retire    = rst && AXI_valid_i && (r_count != '0);

`ifdef WBUF_FLUSH_EN
    logic r_flush_mode;
    logic r_flush_done;
    // The request cycle itself is already blocked.
    assign w_flush_blk  = r_flush_mode | flush_i;
    assign flush_done_o = r_flush_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_mode <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            if (w_flush_blk && r_count == '0) begin
                r_flush_done <= 1'b1;
                r_flush_mode <= 1'b0;
            end else if (flush_i) begin
                r_flush_mode <= 1'b1;
            end
        end
    end
`else
    assign w_flush_blk = 1'b0;
`endif

    assign w_ready    = !w_flush_blk &&
                        (w_merge_hit || (r_count < CNT_W'(DEPTH)) || AXI_valid_i);
    assign wready_o   = w_ready;
    assign w_wacc     = rst && wreq_i && w_ready;
    assign w_do_merge = w_wacc && w_merge_hit;
    assign w_do_alloc = w_wacc && !w_merge_hit;

    // Control state. On a full buffer with a retire, tail == head, so the
    // allocate below overrides the retire's valid clear: the slot is reused.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_whit  <= 1'b0;
            r_rhit  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_whit  <= w_do_merge;
            r_rhit  <= rreq_i && w_rmatch;
            r_rdata <= (rreq_i && w_rmatch) ? r_data[w_ridx] : '0;
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_do_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_do_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents of invalid entries are never observed.
    always_ff @(posedge clk) begin
        if (w_do_alloc) begin
            r_tag[r_tail]  <= w_wtag;
            r_data[r_tail] <= wdata_i & w_bmask;
            r_strb[r_tail] <= wstrb_i;
        end
        if (w_do_merge) begin
            r_data[w_widx] <= w_merged;
            r_strb[w_widx] <= r_strb[w_widx] | wstrb_i;
        end
    end

    assign AXI_wen_o   = (r_count != '0);
    assign AXI_waddr_o = AXI_wen_o ? {r_tag[r_head], {OFFSET_W{1'b0}}} : '0;
    assign AXI_wdata_o = AXI_wen_o ? r_data[r_head] : '0;
    assign AXI_wstrb_o = AXI_wen_o ? r_strb[r_head] : '0;

    always_comb begin
        if (r_count == '0)                state_o = 2'b00;
        else if (r_count == CNT_W'(DEPTH)) state_o = 2'b11;
        else                              state_o = 2'b01;
    end

    assign count_o = r_count;
    assign whit_o  = r_whit;
    assign rhit_o  = r_rhit;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_write_buffer_gen2.sv
module tb_write_buffer_gen2;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wreq = 1'b0;
    logic [31:0]  waddr = '0;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wready;
    logic         whit;
    logic         rreq = 1'b0;
    logic [31:0]  raddr = '0;
    logic         rhit;
    logic [127:0] rdata;
    logic [1:0]   state;
    logic [3:0]   count;
    logic         axi_wen;
    logic [31:0]  axi_waddr;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_valid = 1'b0;
`ifdef WBUF_FLUSH_EN
    logic         flush = 1'b0;
    logic         flush_done;
`endif

    write_buffer_gen2 dut (
        .clk(clk), .rst(rst),
        .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
        .wready_o(wready), .whit_o(whit),
        .rreq_i(rreq), .raddr_i(raddr), .rhit_o(rhit), .rdata_o(rdata),
        .state_o(state), .count_o(count),
`ifdef WBUF_FLUSH_EN
        .flush_i(flush), .flush_done_o(flush_done),
`endif
        .AXI_wen_o(axi_wen), .AXI_waddr_o(axi_waddr), .AXI_wdata_o(axi_wdata),
        .AXI_wstrb_o(axi_wstrb), .AXI_valid_i(axi_valid)
    );

    always #5 clk = ~clk;

    typedef struct { bit rdy; bit hit; } wexp_t;
    typedef struct { bit hit; logic [127:0] data; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Monitor: at each negedge, first compare the registered responses to
    // last cycle's requests, then record this cycle's requests.
    initial begin
        bit           p_w = 0, p_r = 0, p_whit = 0, p_rhit = 0;
        logic [127:0] p_rdata = '0;
        wexp_t        we;
        rexp_t        re;
        forever begin
            @(negedge clk);
            if (p_w) chk("whit", {127'd0, whit}, {127'd0, p_whit});
            if (p_r) begin
                chk("rhit", {127'd0, rhit}, {127'd0, p_rhit});
                chk("rdata", rdata, p_rdata);
            end
            p_w = 0;
            p_r = 0;
            if (rst && wreq) begin
                if (wq.size() == 0) chk("wq_underflow", 128'd1, 128'd0);
                else begin
                    we = wq.pop_front();
                    chk("wready", {127'd0, wready}, {127'd0, we.rdy});
                    p_w    = 1;
                    p_whit = we.rdy && we.hit;
                end
            end
            if (rst && rreq) begin
                if (rq.size() == 0) chk("rq_underflow", 128'd1, 128'd0);
                else begin
                    re      = rq.pop_front();
                    p_r     = 1;
                    p_rhit  = re.hit;
                    p_rdata = re.data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wreq = 0; rreq = 0; axi_valid = 0;
`ifdef WBUF_FLUSH_EN
        flush = 0;
`endif
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                      input bit rdy, input bit hit, input bit axv);
        wexp_t e;
        e.rdy = rdy; e.hit = hit;
        wq.push_back(e);
        waddr = a; wdata = d; wstrb = s; wreq = 1; axi_valid = axv;
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input bit hit, input logic [127:0] d);
        rexp_t e;
        e.hit = hit; e.data = d;
        rq.push_back(e);
        raddr = a; rreq = 1;
        tick();
    endtask

    task automatic retire();
        axi_valid = 1;
        tick();
    endtask

    localparam logic [127:0] D0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D1M = 128'h1111_2222_3333_4444_5555_6666_0000_0000;
    localparam logic [127:0] D2  = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] D3  = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] D4  = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;
    localparam logic [127:0] D4M = 128'h0000_0000_0000_0000_0BAD_F00D_1234_5678;
    localparam logic [127:0] D5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] D9  = 128'h9999_9999_9999_9999_9999_9999_9999_9999;

    initial begin
        logic [31:0] ld;
        tick(); tick();
        rst = 1;
        // Reset state
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_state", 128'(state), 128'd0);
        chk("rst_wen", 128'(axi_wen), 128'd0);
        chk("rst_waddr", 128'(axi_waddr), 128'd0);
        chk("rst_wdata", axi_wdata, 128'd0);
        chk("rst_wstrb", 128'(axi_wstrb), 128'd0);
        chk("rst_rhit", 128'(rhit), 128'd0);

        // Single write and retire
        wr(32'h2468_7571, D0, 16'hFFFF, 1, 0, 0);
        chk("t1_state", 128'(state), 128'd1);
        chk("t1_wen", 128'(axi_wen), 128'd1);
        chk("t1_waddr", 128'(axi_waddr), 128'h2468_7570);
        chk("t1_wdata", axi_wdata, D0);
        chk("t1_wstrb", 128'(axi_wstrb), 128'hFFFF);
        retire();
        chk("t1_state_after", 128'(state), 128'd0);
        chk("t1_wen_after", 128'(axi_wen), 128'd0);

        // Fill, refuse, then allocate while retiring
        for (int i = 0; i < 8; i++) begin
            ld = 32'hA000_0000 + 32'(i);
            wr(32'h1000_0000 + 32'(i * 16), {4{ld}}, 16'hFFFF, 1, 0, 0);
        end
        chk("t2_state_full", 128'(state), 128'd3);
        chk("t2_count_full", 128'(count), 128'd8);
        wr(32'h2000_0000, D9, 16'hFFFF, 0, 0, 0);
        chk("t2_count_drop", 128'(count), 128'd8);
        chk("t2_head_kept", 128'(axi_waddr), 128'h1000_0000);
        wr(32'h2000_0000, D9, 16'hFFFF, 1, 0, 1);
        chk("t2_count_swap", 128'(count), 128'd8);
        chk("t2_new_head_a", 128'(axi_waddr), 128'h1000_0010);
        chk("t2_new_head_d", axi_wdata, {4{32'hA000_0001}});
        rd(32'h2000_0000, 1, D9);
        rd(32'h1000_0000, 0, 128'd0);
        rd(32'h1000_0010, 1, {4{32'hA000_0001}});
        for (int i = 0; i < 8; i++) retire();
        chk("t2_drained", 128'(count), 128'd0);

        // Merge into non-head entry
        wr(32'h3000_0000, D2, 16'hFFFF, 1, 0, 0);
        wr(32'h2461_7570, D1, 16'hFFFF, 1, 0, 0);
        wr(32'h2461_7570, 128'd0, 16'h000F, 1, 1, 0);
        chk("t3_count", 128'(count), 128'd2);
        rd(32'h2461_7570, 1, D1M);
        rd(32'h3000_0000, 1, D2);
        retire(); retire();

        // Write to head line allocates a new entry
        wr(32'h2469_7570, D3, 16'hFFFF, 1, 0, 0);
        wr(32'h2469_7570, D4, 16'h00FF, 1, 0, 0);
        chk("t4_head_data", axi_wdata, D3);
        chk("t4_count", 128'(count), 128'd2);
        rd(32'h2469_7570, 1, D4M);
        retire();
        chk("t4_waddr", 128'(axi_waddr), 128'h2469_7570);
        chk("t4_wdata", axi_wdata, D4M);
        chk("t4_wstrb", 128'(axi_wstrb), 128'h00FF);
        retire();

        // No same-cycle forwarding
        begin
            rexp_t e;
            e.hit = 0; e.data = '0;
            rq.push_back(e);
            raddr = 32'h4000_0000; rreq = 1;
            wr(32'h4000_0000, D5, 16'hFFFF, 1, 0, 0);
        end
        rd(32'h4000_0000, 1, D5);
        retire();

        // Absent read, reset mid-operation
        rd(32'h9961_7570, 0, 128'd0);
        for (int i = 0; i < 3; i++) wr(32'h5000_0000 + 32'(i * 16), D2, 16'hFFFF, 1, 0, 0);
        chk("t5_count3", 128'(count), 128'd3);
        rst = 0;
        tick();
        rst = 1;
        chk("t5_state", 128'(state), 128'd0);
        chk("t5_wen", 128'(axi_wen), 128'd0);
        chk("t5_count", 128'(count), 128'd0);
        retire();
        chk("t5_stray_bvalid", 128'(count), 128'd0);
        wr(32'h6000_0000, D3, 16'hFFFF, 1, 0, 0);
        chk("t5_after", 128'(count), 128'd1);

`ifdef WBUF_FLUSH_EN
        wr(32'h6000_0010, D3, 16'hFFFF, 1, 0, 0);
        flush = 1;
        tick();
        wr(32'h7000_0000, D5, 16'hFFFF, 0, 0, 0);
        retire(); retire();
        chk("f_done_early", 128'(flush_done), 128'd0);
        tick();
        chk("f_done", 128'(flush_done), 128'd1);
        tick();
        chk("f_done_clear", 128'(flush_done), 128'd0);
        wr(32'h7000_0000, D5, 16'hFFFF, 1, 0, 0);
        chk("f_after", 128'(count), 128'd1);
`endif

        tick(); tick();
        chk("wq_empty", 128'(wq.size()), 128'd0);
        chk("rq_empty", 128'(rq.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
